// File: rtl/mem_stage.sv
// Memory stage of the in-order pipeline: M and W pipeline registers, data-memory
// request generation, M-stage forwarding source and a W-stage load hold buffer.
module mem_stage #(
  parameter int DAW = 30
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           ex_valid,
  input  logic [31:0]    ex_result,
  input  logic [31:0]    ex_stdata,
  input  logic [4:0]     ex_rd,
  input  logic           ex_we,
  input  logic           ex_ld,
  input  logic           ex_st,
  input  logic           stall,
  output logic           DREQ,
  output logic           DRW,
  output logic [DAW-1:0] DADDR,
  output logic [31:0]    DWDATA,
  input  logic [31:0]    DRDATA,
  output logic           fwd_m_en,
  output logic [4:0]     fwd_m_rd,
  output logic [31:0]    fwd_m_data,
  output logic           load_use,
  output logic           wb_we,
  output logic [4:0]     wb_rd,
  output logic [31:0]    wb_data
);

  logic        m_valid_q, m_we_q, m_ld_q, m_st_q;
  logic [31:0] m_result_q, m_stdata_q;
  logic [4:0]  m_rd_q;

  logic        w_valid_q, w_we_q, w_ld_q;
  logic [31:0] w_result_q;
  logic [4:0]  w_rd_q;

  logic        hold_vld_q, hold_vld_d;
  logic [31:0] hold_data_q, hold_data_d;

  // M register: loads from EX unless the pipeline is held.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m_valid_q  <= 1'b0;
      m_result_q <= '0;
      m_stdata_q <= '0;
      m_rd_q     <= '0;
      m_we_q     <= 1'b0;
      m_ld_q     <= 1'b0;
      m_st_q     <= 1'b0;
    end else if (!stall) begin
      m_valid_q  <= ex_valid;
      m_result_q <= ex_result;
      m_stdata_q <= ex_stdata;
      m_rd_q     <= ex_rd;
      m_we_q     <= ex_we;
      m_ld_q     <= ex_ld;
      m_st_q     <= ex_st;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      w_valid_q  <= 1'b0;
      w_result_q <= '0;
      w_rd_q     <= '0;
      w_we_q     <= 1'b0;
      w_ld_q     <= 1'b0;
    end else if (!stall) begin
      w_valid_q  <= m_valid_q;
      w_result_q <= m_result_q;
      w_rd_q     <= m_rd_q;
      w_we_q     <= m_we_q;
      w_ld_q     <= m_ld_q;
    end
  end

  // DRDATA is only valid for one cycle; a stalled load in W keeps its copy here.
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (!stall) begin
      hold_vld_d = 1'b0;
    end else if (w_valid_q && w_ld_q && !hold_vld_q) begin
      hold_vld_d  = 1'b1;
      hold_data_d = DRDATA;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  // Requests are suppressed while stalled so a held store is issued only once.
  always_comb begin
    DREQ   = m_valid_q && (m_ld_q || m_st_q) && !stall;
    DRW    = m_st_q;
    DADDR  = m_result_q[DAW+1:2];
    DWDATA = m_st_q ? m_stdata_q : 32'd0;
  end

  always_comb begin
    fwd_m_en   = m_valid_q && m_we_q && !m_ld_q;
    fwd_m_rd   = m_rd_q;
    fwd_m_data = m_result_q;
    load_use   = m_valid_q && m_ld_q && m_we_q;
  end

  always_comb begin
    wb_we = w_valid_q && w_we_q && !stall;
    wb_rd = w_rd_q;
    if (hold_vld_q)  wb_data = hold_data_q;
    else if (w_ld_q) wb_data = DRDATA;
    else             wb_data = w_result_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, loads, ALU forwarding, stalls, bubbles
// and mid-operation reset, with a one-cycle-latency memory responder.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_stdata;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic        ex_ld;
  logic        ex_st;
  logic        stall;
  logic        dreq;
  logic        drw;
  logic [29:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        fwd_m_en;
  logic [4:0]  fwd_m_rd;
  logic [31:0] fwd_m_data;
  logic        load_use;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_assert;
  int n_fail;

  logic [31:0] mem_val;
  logic [31:0] mem_next;

  mem_stage #(.DAW(30)) dut (
    .CLK        (clk),
    .RSTN       (rst_n),
    .ex_valid   (ex_valid),
    .ex_result  (ex_result),
    .ex_stdata  (ex_stdata),
    .ex_rd      (ex_rd),
    .ex_we      (ex_we),
    .ex_ld      (ex_ld),
    .ex_st      (ex_st),
    .stall      (stall),
    .DREQ       (dreq),
    .DRW        (drw),
    .DADDR      (daddr),
    .DWDATA     (dwdata),
    .DRDATA     (drdata),
    .fwd_m_en   (fwd_m_en),
    .fwd_m_rd   (fwd_m_rd),
    .fwd_m_data (fwd_m_data),
    .load_use   (load_use),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: read data appears the cycle after a read request,
  // otherwise the bus floats to all ones.
  always @(posedge clk) drdata <= mem_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic [31:0] res, input logic [31:0] sd,
                        input logic [4:0] rd, input logic we, input logic ld, input logic st);
    ex_valid  = v;
    ex_result = res;
    ex_stdata = sd;
    ex_rd     = rd;
    ex_we     = we;
    ex_ld     = ld;
    ex_st     = st;
  endtask

  task automatic idle();
    set_ex(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called mid-cycle after checks: schedule memory response, move to next negedge.
  task automatic advance();
    mem_next = (dreq && !drw) ? mem_val : 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    stall    = 1'b0;
    mem_val  = 32'd0;
    mem_next = 32'hFFFF_FFFF;
    drdata   = 32'd0;
    idle();

    // Reset values
    #1;
    chk("rst_dreq",     32'(dreq),     32'd0);
    chk("rst_drw",      32'(drw),      32'd0);
    chk("rst_daddr",    32'(daddr),    32'd0);
    chk("rst_dwdata",   dwdata,        32'd0);
    chk("rst_wb_we",    32'(wb_we),    32'd0);
    chk("rst_fwd_en",   32'(fwd_m_en), 32'd0);
    chk("rst_load_use", 32'(load_use), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_dreq",  32'(dreq),  32'd0);
    chk("rel_wb_we", 32'(wb_we), 32'd0);
    advance();
    chk("rel1_dreq",     32'(dreq),     32'd0);
    chk("rel1_load_use", 32'(load_use), 32'd0);

    // Store
    set_ex(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1);
    advance();
    idle();
    chk("st_dreq",   32'(dreq),     32'd1);
    chk("st_drw",    32'(drw),      32'd1);
    chk("st_daddr",  32'(daddr),    32'h41);
    chk("st_dwdata", dwdata,        32'hDEAD_BEEF);
    chk("st_fwd_en", 32'(fwd_m_en), 32'd0);
    advance();
    chk("st_once",   32'(dreq),     32'd0);
    chk("st_wb_we",  32'(wb_we),    32'd0);

    // Load
    mem_val = 32'h1234_5678;
    set_ex(1'b1, 32'h0000_0020, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    advance();
    idle();
    chk("ld_dreq",     32'(dreq),     32'd1);
    chk("ld_drw",      32'(drw),      32'd0);
    chk("ld_daddr",    32'(daddr),    32'h8);
    chk("ld_load_use", 32'(load_use), 32'd1);
    chk("ld_fwd_en",   32'(fwd_m_en), 32'd0);
    chk("ld_dwdata",   dwdata,        32'd0);
    advance();
    chk("ld_wb_we",    32'(wb_we),    32'd1);
    chk("ld_wb_rd",    32'(wb_rd),    32'd3);
    chk("ld_wb_data",  wb_data,       32'h1234_5678);
    chk("ld_dreq_w",   32'(dreq),     32'd0);
    advance();
    chk("ld_wb_once",  32'(wb_we),    32'd0);

    // ALU op
    set_ex(1'b1, 32'h0000_0055, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    advance();
    idle();
    chk("alu_fwd_en",   32'(fwd_m_en), 32'd1);
    chk("alu_fwd_rd",   32'(fwd_m_rd), 32'd7);
    chk("alu_fwd_data", fwd_m_data,    32'h55);
    chk("alu_dreq",     32'(dreq),     32'd0);
    advance();
    chk("alu_wb_we",    32'(wb_we),    32'd1);
    chk("alu_wb_rd",    32'(wb_rd),    32'd7);
    chk("alu_wb_data",  wb_data,       32'h55);

    // Stall for three cycles while the load sits in W
    mem_val = 32'hCAFE_0001;
    set_ex(1'b1, 32'h0000_0040, 32'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    advance();
    idle();
    chk("sl_dreq",  32'(dreq),  32'd1);
    chk("sl_daddr", 32'(daddr), 32'h10);
    advance();
    stall = 1'b1;
    #1;
    chk("sl_we_s1", 32'(wb_we), 32'd0);
    advance();
    chk("sl_we_s2",   32'(wb_we), 32'd0);
    chk("sl_data_s2", wb_data,    32'hCAFE_0001);
    advance();
    chk("sl_we_s3",   32'(wb_we), 32'd0);
    chk("sl_bus",     drdata,     32'hFFFF_FFFF);
    chk("sl_data_s3", wb_data,    32'hCAFE_0001);
    advance();
    stall = 1'b0;
    #1;
    chk("sl_we_rel",   32'(wb_we), 32'd1);
    chk("sl_rd_rel",   32'(wb_rd), 32'd5);
    chk("sl_data_rel", wb_data,    32'hCAFE_0001);
    advance();
    chk("sl_we_once",  32'(wb_we), 32'd0);

    // Stall for two cycles while a misaligned store sits in M
    set_ex(1'b1, 32'h0000_0203, 32'hA5A5_5A5A, 5'd0, 1'b0, 1'b0, 1'b1);
    advance();
    idle();
    stall = 1'b1;
    #1;
    chk("ss_dreq_s1", 32'(dreq), 32'd0);
    advance();
    chk("ss_dreq_s2", 32'(dreq), 32'd0);
    advance();
    stall = 1'b0;
    #1;
    chk("ss_dreq",   32'(dreq),  32'd1);
    chk("ss_drw",    32'(drw),   32'd1);
    chk("ss_daddr",  32'(daddr), 32'h80);
    chk("ss_dwdata", dwdata,     32'hA5A5_5A5A);
    advance();
    chk("ss_once",   32'(dreq),  32'd0);

    // Bubble carrying load/we flags must do nothing
    set_ex(1'b0, 32'h0000_0030, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0);
    advance();
    idle();
    chk("bub_dreq",     32'(dreq),     32'd0);
    chk("bub_load_use", 32'(load_use), 32'd0);
    chk("bub_fwd_en",   32'(fwd_m_en), 32'd0);
    advance();
    chk("bub_wb_we",    32'(wb_we),    32'd0);

    // Reset while a load is in M
    mem_val = 32'h0BAD_0BAD;
    set_ex(1'b1, 32'h0000_0060, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0);
    advance();
    idle();
    chk("mr_dreq_pre", 32'(dreq), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_dreq",     32'(dreq),     32'd0);
    chk("mr_load_use", 32'(load_use), 32'd0);
    advance();
    chk("mr_wb_we_rst", 32'(wb_we), 32'd0);
    rst_n = 1'b1;
    #1;
    advance();
    chk("mr_wb_we_1", 32'(wb_we), 32'd0);
    chk("mr_dreq_1",  32'(dreq),  32'd0);
    advance();
    chk("mr_wb_we_2", 32'(wb_we), 32'd0);

    // Recovery with a fresh ALU op
    set_ex(1'b1, 32'h0000_0077, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    advance();
    idle();
    chk("rc_fwd_en",   32'(fwd_m_en), 32'd1);
    chk("rc_fwd_data", fwd_m_data,    32'h77);
    advance();
    chk("rc_wb_we",    32'(wb_we),    32'd1);
    chk("rc_wb_data",  wb_data,       32'h77);
    chk("rc_wb_rd",    32'(wb_rd),    32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: DAW, 30, width of the word address on DADDR; only value 30 is supported.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RSTN  in  1  asynchronous, active-low reset.
REQ-004 ex_valid  in  1  EX stage presents a valid instruction this cycle.
REQ-005 ex_result  in  32  ALU result; byte effective address for LD/LDR/ST/STR.
REQ-006 ex_stdata  in  32  store data (rb/ra register value) for ST/STR.
REQ-007 ex_rd  in  5  destination register index.
REQ-008 ex_we  in  1  instruction writes the register file.
REQ-009 ex_ld / ex_st  in  1 each  instruction is a load / store; never both high.
REQ-010 stall  in  1  global hold from the hazard unit.
REQ-011 DREQ  out  1  data memory request, active high.
REQ-012 DRW  out  1  1 = write, 0 = read; meaningful only when DREQ=1.
REQ-013 DADDR  out  DAW  word address.
REQ-014 DWDATA  out  32  write data.
REQ-015 DRDATA  in  32  read data, valid the cycle after a read request.
REQ-016 fwd_m_en / fwd_m_rd / fwd_m_data  out  1/5/32  forwarding source from the M register (non-load results only).
REQ-017 load_use  out  1  M register holds a valid load with ex_we; the hazard unit stalls EX on an rd match.
REQ-018 wb_we / wb_rd / wb_data  out  1/5/32  register-file write port of the W stage.

Function
REQ-019 M register: captures {valid, result, stdata, rd, we, ld, st} from EX on each rising edge when stall=0; it holds when stall=1.
REQ-020 W register: captures {valid, result, rd, we, ld} from M on each rising edge when stall=0; it holds when stall=1.
REQ-021 DREQ = m_valid & (m_ld | m_st) & ~stall; a request is never issued during a stall cycle, so no store is duplicated.
REQ-022 DRW = m_st; DADDR = m_result[31:2]; address bits [1:0] are ignored and misaligned accesses are silently truncated.
REQ-023 DWDATA = m_stdata when m_st; otherwise 0.
REQ-024 Load latency: the request is issued in cycle t and the value reaches wb_data in cycle t+1, which is the W cycle of that load.
REQ-025 wb_data: hold_data when hold_vld=1; else DRDATA when w_ld=1; else w_result.
REQ-026 wb_we = w_valid & w_we & ~stall; the register file is written exactly once per instruction.
REQ-027 Load hold buffer: in the first stall cycle with w_valid & w_ld & ~hold_vld, DRDATA is captured into hold_data and hold_vld is set.
REQ-028 hold_vld clears on the first rising edge with stall=0.
REQ-029 fwd_m_en = m_valid & m_we & ~m_ld; fwd_m_rd = m_rd; fwd_m_data = m_result.
REQ-030 load_use = m_valid & m_ld & m_we.
REQ-031 ex_valid=0 inserts a bubble: M is loaded with valid=0, and no DREQ or wb_we results from it.
REQ-032 Writes to r0 are not filtered here; the register file owns that rule.
REQ-033 When stall deasserts, a held load or store in M issues DREQ in the first non-stall cycle.

Reset
REQ-034 While RSTN=0, all valid flags, we, ld, st, and hold_vld are 0, and all data/address registers are 0.
REQ-035 Consequently DREQ, DRW, DADDR, DWDATA, wb_we, fwd_m_en and load_use are all 0 during reset and in the first cycle after release.
REQ-036 Reset asserted mid-operation aborts in-flight instructions without any further DREQ or wb_we.

Verification
REQ-037 Store: ex_st, result=0x0000_0104, stdata=0xDEAD_BEEF -> next cycle DREQ=1, DRW=1, DADDR=0x41, DWDATA=0xDEAD_BEEF for exactly one cycle.
REQ-038 Load: ex_ld, we, rd=3, result=0x20; memory returns 0x1234_5678 -> request cycle DREQ=1, DRW=0, DADDR=0x8, load_use=1; next cycle wb_we=1, wb_rd=3, wb_data=0x1234_5678.
REQ-039 ALU op: ADD result 0x55, rd=7 -> M cycle fwd_m_en=1, fwd_m_rd=7, fwd_m_data=0x55, DREQ=0; next cycle wb_data=0x55, wb_we=1.
REQ-040 Stall during load W: stall for 3 cycles while memory output changes to 0xFFFF_FFFF -> wb_we=0 during the stall; after release a single wb_we with wb_data equal to the original load value.
REQ-041 Stall during store M: stall for 2 cycles -> DREQ=0 throughout the stall, then exactly one write request.
REQ-042 Reset: RSTN low in the cycle a load is in M -> DREQ=0 immediately, and no wb_we after release until a new instruction arrives.
